// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a shared memory bus; optional grant timeout via MEM_ARBITER_TIMEOUT_EN
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF, DONE} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 2..255");
  end

  state_t      state, state_nxt;
  logic        last_mem;     // 1: most recent grant went to the data port
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_sel;
  logic [31:0] rdata_q;
  logic        timeout_hit;
  logic        grant_mem;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  logic       err_q;
  assign timeout_hit = (cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Data port wins unless it also won last time and fetch is waiting.
  assign grant_mem = mem_req & ~(last_mem & if_req);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision; DONE never samples requests.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_mem)   state_nxt = GNT_MEM;
        else if (if_req) state_nxt = GNT_IF;
        else             state_nxt = IDLE;
      end
      GNT_MEM, GNT_IF: begin
        if (bus_ack || timeout_hit) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, read-data capture and grant-age counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_mem  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= '0;
      rdata_q   <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
          cnt <= '0;
`endif
          if (state_nxt == GNT_MEM) begin
            last_mem  <= 1'b1;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
            lat_we    <= mem_we;
            lat_sel   <= mem_sel;
          end else if (state_nxt == GNT_IF) begin
            last_mem  <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'hF;
          end
        end
        GNT_MEM, GNT_IF: begin
          if (bus_ack) begin
            rdata_q <= lat_we ? 32'h0 : bus_rdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end else if (timeout_hit) begin
            rdata_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end else begin
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt <= cnt + 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Bus drive during grants, completion pulse and read data in DONE.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_sel   = '0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    if_rdata  = '0;
    mem_rdata = '0;
    bus_err   = 1'b0;
    case (state)
      GNT_MEM, GNT_IF: begin
        bus_req   = 1'b1;
        bus_we    = lat_we;
        bus_addr  = lat_addr;
        bus_wdata = lat_wdata;
        bus_sel   = lat_sel;
      end
      DONE: begin
        if_ack  = ~last_mem;
        mem_ack = last_mem;
        if (last_mem) mem_rdata = rdata_q;
        else          if_rdata  = rdata_q;
`ifdef MEM_ARBITER_TIMEOUT_EN
        bus_err = err_q;
`endif
      end
      default: ;
    endcase
  end

  assign stallreq = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq(stallreq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_wdata = 0; mem_sel = 0; bus_rdata = 0; bus_ack = 0;
    cyc(); cyc();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stallreq, 0);
    rst = 1'b0;
    cyc();

    // Fetch only, zero wait states.
    if_req = 1; if_addr = 32'h100; #1;
    chk("f_stall_n", stallreq, 1);
    chk("f_bus_req_n", bus_req, 0);
    cyc();
    chk("f_bus_req", bus_req, 1);
    chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_sel", bus_sel, 4'hF);
    chk("f_bus_we", bus_we, 0);
    chk("f_stall_n1", stallreq, 1);
    bus_ack = 1; bus_rdata = 32'h3C010001;
    cyc();
    bus_ack = 0; #1;
    chk("f_if_ack", if_ack, 1);
    chk("f_if_rdata", if_rdata, 32'h3C010001);
    chk("f_bus_req_done", bus_req, 0);
    chk("f_stall_done", stallreq, 0);
    if_req = 0;
    cyc();
    chk("f_if_ack_idle", if_ack, 0);
    chk("f_if_rdata_idle", if_rdata, 0);

    // Contention: store and fetch together, store first.
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_sel = 4'b0011;
    cyc();
    chk("c_bus_we", bus_we, 1);
    chk("c_bus_addr", bus_addr, 32'h200);
    chk("c_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("c_bus_sel", bus_sel, 4'b0011);
    bus_ack = 1; bus_rdata = 32'h12345678;
    cyc();
    bus_ack = 0; #1;
    chk("c_mem_ack", mem_ack, 1);
    chk("c_mem_rdata_store", mem_rdata, 0);
    chk("c_if_ack_n", if_ack, 0);
    chk("c_stall_done", stallreq, 1);
    mem_req = 0; mem_we = 0;
    cyc();
    chk("c_idle_bus_req", bus_req, 0);
    cyc();
    chk("c_if_bus_addr", bus_addr, 32'h104);
    chk("c_if_bus_we", bus_we, 0);
    bus_ack = 1; bus_rdata = 32'hCAFE0001;
    cyc();
    bus_ack = 0; #1;
    chk("c_if_ack", if_ack, 1);
    chk("c_if_rdata", if_rdata, 32'hCAFE0001);
    chk("c_mem_ack_n", mem_ack, 0);
    if_req = 0;
    cyc();

    // Both held after reset: MEM, IF, MEM, IF.
    rst = 1; cyc(); rst = 0;
    if_req = 1; if_addr = 32'h400;
    mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_sel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 4 && !bus_req; w++) cyc();
      chk($sformatf("alt_req%0d", k), bus_req, 1);
      chk($sformatf("alt_addr%0d", k), bus_addr, (k % 2 == 0) ? 32'h300 : 32'h400);
      bus_ack = 1; bus_rdata = 32'hA0 + k;
      cyc();
      bus_ack = 0; #1;
      chk($sformatf("alt_mack%0d", k), mem_ack, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_iack%0d", k), if_ack, (k % 2 == 0) ? 0 : 1);
      chk($sformatf("alt_rd%0d", k), (k % 2 == 0) ? mem_rdata : if_rdata, 32'hA0 + k);
      if (k == 3) begin
        if_req = 0; mem_req = 0;
      end
    end
    cyc();

    // Wait states: bus_ack five cycles late.
    mem_req = 1; mem_we = 1; mem_addr = 32'h500; mem_wdata = 32'h11112222; mem_sel = 4'hC;
    cyc();
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("ws_req%0d", w), bus_req, 1);
      chk($sformatf("ws_addr%0d", w), bus_addr, 32'h500);
      chk($sformatf("ws_wdata%0d", w), bus_wdata, 32'h11112222);
      chk($sformatf("ws_ack%0d", w), mem_ack, 0);
      cyc();
    end
    bus_ack = 1; bus_rdata = 32'h55555555;
    cyc();
    bus_ack = 0; #1;
    chk("ws_mem_ack", mem_ack, 1);
    chk("ws_bus_req_done", bus_req, 0);
    cyc();
    chk("ws_mem_ack_once", mem_ack, 0);
    chk("ws_bus_req_idle", bus_req, 0);
    mem_req = 0; mem_we = 0;
    cyc();

    // Reset during GNT_MEM.
    mem_req = 1; mem_addr = 32'h600;
    cyc();
    chk("r_bus_req", bus_req, 1);
    rst = 1; bus_ack = 1; bus_rdata = 32'h77777777;
    cyc();
    chk("r_bus_req_after", bus_req, 0);
    chk("r_mem_ack", mem_ack, 0);
    chk("r_mem_rdata", mem_rdata, 0);
    chk("r_bus_err", bus_err, 0);
    chk("r_stall", stallreq, 1);
    rst = 0; bus_ack = 0; mem_req = 0;
    cyc();
    chk("r_mem_ack_late", mem_ack, 0);

    // bus_ack in IDLE is ignored.
    bus_ack = 1;
    cyc();
    bus_ack = 0; #1;
    chk("i_if_ack", if_ack, 0);
    chk("i_mem_ack", mem_ack, 0);
    chk("i_bus_req", bus_req, 0);

    // Unacknowledged grant.
    mem_req = 1; mem_we = 0; mem_addr = 32'h700; bus_rdata = 32'hFFFFFFFF;
    cyc();
`ifdef MEM_ARBITER_TIMEOUT_EN
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("to_req%0d", w), bus_req, 1);
      chk($sformatf("to_err%0d", w), bus_err, 0);
      cyc();
    end
    chk("to_mem_ack", mem_ack, 1);
    chk("to_mem_rdata", mem_rdata, 0);
    chk("to_bus_err", bus_err, 1);
    mem_req = 0;
    cyc();
    chk("to_err_clear", bus_err, 0);
    chk("to_ack_clear", mem_ack, 0);
`else
    for (int w = 0; w < 10; w++) begin
      chk($sformatf("nt_req%0d", w), bus_req, 1);
      chk($sformatf("nt_err%0d", w), bus_err, 0);
      cyc();
    end
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    cyc();
    bus_ack = 0; mem_req = 0; #1;
    chk("nt_mem_ack", mem_ack, 1);
    chk("nt_mem_rdata", mem_rdata, 32'h0BADF00D);
    chk("nt_bus_err", bus_err, 0);
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
